// File: rtl/mem_txn_engine_pkg.sv
// Shared definitions for the memory transaction engine: FSM states,
// default widths and the canonical request layout.
package definesPkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 256;
  localparam int unsigned DEF_QDEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
    logic                  wr;
  } mem_req_s;

endpackage

// File: rtl/mem_txn_engine_txn_fifo.sv
// Request queue: power-of-2 depth, show-ahead read, pointers carry one
// extra wrap bit so full and empty are told apart without a counter.
module txn_fifo #(
  parameter int unsigned WIDTH  = 17,
  parameter int unsigned QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IW = $clog2(QDEPTH);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [QDEPTH];
  logic             w_push;
  logic             w_pop;

  // Same slot index with differing wrap bits means the writer lapped the reader.
  assign full  = (r_wr_ptr[IW] != r_rd_ptr[IW]) &&
                 (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign rdata = r_mem[r_rd_ptr[IW-1:0]];

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[IW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mem_txn_engine.sv
// Queued single-port memory engine: requests are buffered in txn_fifo and
// executed one at a time through IDLE -> EXEC -> RESP, responses in order.
module mem_txn_engine #(
  parameter int unsigned ADDR_W = definesPkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = definesPkg::DEF_DATA_W,
  parameter int unsigned DEPTH  = definesPkg::DEF_DEPTH,
  parameter int unsigned QDEPTH = definesPkg::DEF_QDEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_wr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_wr,
  output logic              rsp_err,
  output logic              busy
);

  import definesPkg::*;

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned REQ_W = ADDR_W + DATA_W + 1;

  // Field order matches mem_req_s; widths follow this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wr;
  } req_t;

  state_e            r_state;
  req_t              r_cur;
  req_t              w_push_req;
  logic [REQ_W-1:0]  w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_wr;
  logic              r_rsp_err;

  assign w_push_req = '{addr: req_addr, data: req_data, wr: req_wr};
  assign w_pop      = (r_state == IDLE);

  txn_fifo #(
    .WIDTH  (REQ_W),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid),
    .wdata (w_push_req),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Compare one bit wider so DEPTH == 2**ADDR_W stays representable.
  assign w_in_range = ({1'b0, r_cur.addr} < (ADDR_W + 1)'(DEPTH));
  assign w_idx      = r_cur.addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cur      <= '0;
      r_rsp_data <= '0;
      r_rsp_wr   <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_cur   <= req_t'(w_head);
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_wr   <= r_cur.wr;
          r_rsp_err  <= !w_in_range;
          r_rsp_data <= (w_in_range && !r_cur.wr) ? r_mem[w_idx] : '0;
          r_state    <= RESP;
        end
        RESP: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Contents survive reset; only an in-range EXEC write touches the array.
  always_ff @(posedge clk) begin
    if ((r_state == EXEC) && r_cur.wr && w_in_range) r_mem[w_idx] <= r_cur.data;
  end

  assign req_ready = !w_full;
  assign rsp_valid = (r_state == RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_wr    = r_rsp_wr;
  assign rsp_err   = r_rsp_err;
  assign busy      = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_mem_txn_engine.sv
// Directed bench for mem_txn_engine (DEPTH=200, QDEPTH=4).
module tb_mem_txn_engine;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic       req_wr;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_wr;
  logic       rsp_err;
  logic       busy;

  int unsigned n_checks;
  int unsigned n_fail;

  mem_txn_engine #(
    .ADDR_W (8),
    .DATA_W (8),
    .DEPTH  (200),
    .QDEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_wr    (req_wr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_wr    (rsp_wr),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one request and returns at the next negedge.
  task automatic send(input logic [7:0] a, input logic [7:0] d, input logic w);
    int unsigned n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check_eq("send_timeout", 0, 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_wr    = w;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called at a negedge with rsp_ready=1; checks one response and consumes it.
  task automatic expect_rsp(input string tag, input logic [7:0] d, input logic w,
                            input logic e, output time t);
    int unsigned n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    t = $time;
    if (!rsp_valid) begin
      check_eq({tag, "_timeout"}, 0, 1);
    end else begin
      check_eq({tag, "_data"}, rsp_data, d);
      check_eq({tag, "_wr"}, rsp_wr, w);
      check_eq({tag, "_err"}, rsp_err, e);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time        t;
    time        tprev;
    logic [7:0] bp_a [6];
    logic [7:0] bp_d [6];
    logic       bp_w [6];
    int unsigned idx;
    logic       acc_now;

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_wr    = 1'b0;
    rsp_ready = 1'b1;
    tprev     = 0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read, with minimum latency on the write
    send(8'h10, 8'hA5, 1'b1);
    check_eq("lat_n0", rsp_valid, 0);
    @(negedge clk);
    check_eq("lat_n1", rsp_valid, 0);
    @(negedge clk);
    check_eq("lat_n2", rsp_valid, 1);
    expect_rsp("wr10", 8'h00, 1'b1, 1'b0, t);
    send(8'h10, 8'h00, 1'b0);
    expect_rsp("rd10", 8'hA5, 1'b0, 1'b0, t);

    // Out-of-range boundary at DEPTH=200
    send(8'hC7, 8'h5C, 1'b1);
    expect_rsp("wrC7", 8'h00, 1'b1, 1'b0, t);
    send(8'hC8, 8'h00, 1'b0);
    expect_rsp("rdC8", 8'h00, 1'b0, 1'b1, t);
    send(8'hC8, 8'hFF, 1'b1);
    expect_rsp("wrC8", 8'h00, 1'b1, 1'b1, t);
    send(8'hC7, 8'h00, 1'b0);
    expect_rsp("rdC7", 8'h5C, 1'b0, 1'b0, t);

    // Backpressure: 6 offered, 5 accepted
    bp_a = '{8'h10, 8'h20, 8'h21, 8'h20, 8'hC8, 8'h22};
    bp_d = '{8'h00, 8'h61, 8'h62, 8'h00, 8'h00, 8'h63};
    bp_w = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      if (idx < 6) begin
        req_valid = 1'b1;
        req_addr  = bp_a[idx];
        req_data  = bp_d[idx];
        req_wr    = bp_w[idx];
      end else begin
        req_valid = 1'b0;
      end
      acc_now = req_ready && (idx < 6);
      @(negedge clk);
      if (acc_now) idx++;
    end
    req_valid = 1'b0;
    check_eq("bp_accepted", idx, 5);
    check_eq("bp_req_ready", req_ready, 0);
    check_eq("bp_busy", busy, 1);
    for (int c = 0; c < 3; c++) begin
      check_eq("bp_hold_valid", rsp_valid, 1);
      check_eq("bp_hold_data", rsp_data, 8'hA5);
      check_eq("bp_hold_wr", rsp_wr, 0);
      check_eq("bp_hold_err", rsp_err, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    expect_rsp("bp0", 8'hA5, 1'b0, 1'b0, t);
    expect_rsp("bp1", 8'h00, 1'b1, 1'b0, t);
    expect_rsp("bp2", 8'h00, 1'b1, 1'b0, t);
    expect_rsp("bp3", 8'h61, 1'b0, 1'b0, t);
    expect_rsp("bp4", 8'h00, 1'b0, 1'b1, t);
    check_eq("bp_idle_busy", busy, 0);
    check_eq("bp_idle_ready", req_ready, 1);

    // Ordering and throughput: 8 writes then 8 reads back to back
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          if (i < 8) send(8'(i), 8'(8'h30 + i), 1'b1);
          else       send(8'(i - 8), 8'h00, 1'b0);
        end
      end
      begin
        for (int j = 0; j < 16; j++) begin
          if (j < 8) expect_rsp("ord_wr", 8'h00, 1'b1, 1'b0, t);
          else       expect_rsp("ord_rd", 8'(8'h30 + j - 8), 1'b0, 1'b0, t);
          if (j > 0) check_eq("ord_spacing", 32'(t - tprev), 32'd30);
          tprev = t;
        end
      end
    join

    // Reset with the FSM in EXEC and 3 requests queued
    send(8'h10, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) send(8'h10, 8'hEE, 1'b1);
    check_eq("mid_pre_busy", busy, 1);
    check_eq("mid_pre_valid", rsp_valid, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", rsp_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", req_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("mid_no_stale", rsp_valid, 0);
    end
    check_eq("mid_post_busy", busy, 0);
    send(8'h10, 8'h00, 1'b0);
    expect_rsp("mid_rd10", 8'hA5, 1'b0, 1'b0, t);
    send(8'h21, 8'h00, 1'b0);
    expect_rsp("mid_rd21", 8'h62, 1'b0, 1'b0, t);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
